// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with a one-word holding buffer so that back-to-back
// words stream without gaps; emits LANES bits per beat, LSB- or MSB-chunk first.
module piso_stream #(
    parameter int unsigned SIZE      = 8,
    parameter int unsigned LANES     = 1,
    parameter int unsigned SHIFT_DIR = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [SIZE-1:0]  i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_enable,
    output logic [LANES-1:0] o_out,
    output logic             o_out_valid,
    output logic             o_done,
    output logic             o_busy
);

    localparam int unsigned BEATS = SIZE / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (SIZE < 2) begin : g_bad_size
        $error("piso_stream: SIZE must be at least 2");
    end
    if (SIZE % LANES != 0) begin : g_bad_lanes
        $error("piso_stream: SIZE must be a multiple of LANES");
    end

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           r_state, w_state_nxt;
    logic [SIZE-1:0]  r_shreg, w_shreg_nxt;
    logic [BW-1:0]    r_beat, w_beat_nxt;
    logic [SIZE-1:0]  r_hold, w_hold_nxt;
    logic             r_hold_full, w_hold_full_nxt;
    logic [LANES-1:0] r_out, w_out_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_done, w_done_nxt;

    logic             w_accept;
    logic [31:0]      w_lo;
    logic [LANES-1:0] w_chunk;

    assign o_in_ready  = !r_hold_full && !i_reset;
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;
    assign o_busy      = (r_state == StShift);

    // Bit offset of the current chunk; MSB-first walks down from the top chunk.
    always_comb begin
        if (SHIFT_DIR == 0) begin
            w_lo = 32'(r_beat) * LANES;
        end else begin
            w_lo = SIZE - LANES - 32'(r_beat) * LANES;
        end
        w_chunk = LANES'(r_shreg >> w_lo);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_beat_nxt      = r_beat;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;

        // in_ready is low while the buffer is full, so this never collides with a reload.
        if (w_accept) begin
            w_hold_nxt      = i_in_data;
            w_hold_full_nxt = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (r_hold_full) begin
                    w_shreg_nxt     = r_hold;
                    w_hold_full_nxt = 1'b0;
                    w_beat_nxt      = '0;
                    w_state_nxt     = StShift;
                end
            end
            StShift: begin
                if (i_enable) begin
                    w_out_nxt       = w_chunk;
                    w_out_valid_nxt = 1'b1;
                    w_beat_nxt      = r_beat + 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_done_nxt = 1'b1;
                        w_beat_nxt = '0;
                        if (r_hold_full) begin
                            w_shreg_nxt     = r_hold;
                            w_hold_full_nxt = 1'b0;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_shreg     <= '0;
            r_beat      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_beat      <= w_beat_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready load port, a one-word holding buffer for gapless back-to-back words, and a multi-lane output. It sits between a parallel word source (register file, FIFO, packet builder) and a narrow serial link or pin interface. It supports LSB-first or MSB-first order, a cycle-level stall, and per-word completion strobes.

## Interface
- SIZE, 8: word width in bits; ≥2.
- LANES, 1: output bits per beat; SIZE % LANES must be 0 (simulation $error otherwise). BEATS = SIZE/LANES.
- SHIFT_DIR, 0: 0 = LSB chunk first, 1 = MSB chunk first.

- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state on the next posedge.
- in_data  in  SIZE  parallel word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  combinational: !hold_full && !reset.
- enable  in  1  shift enable; low stalls output beats.
- out  out  LANES  current serial chunk (registered).
- out_valid  out  1  out carries a fresh chunk this cycle.
- done  out  1  one-cycle strobe, coincident with a word's last chunk.
- busy  out  1  high while a word is in the shift register (state SHIFT).

## Operation
- Internal state: shreg[SIZE], beat counter (clog2(BEATS) bits, min 1), hold[SIZE], hold_full, state {IDLE, SHIFT}.
- Accept: in_valid && in_ready at a posedge → hold <= in_data, hold_full <= 1. Accept is independent of enable.
- IDLE with hold_full → shreg <= hold, hold_full <= 0, beat <= 0, state <= SHIFT. enable is not required.
- SHIFT with enable=1, per posedge:
  - out <= chunk(beat), out_valid <= 1, beat <= beat+1.
  - chunk(k), DIR=0: shreg[k*LANES +: LANES].
  - chunk(k), DIR=1: shreg[SIZE-1-k*LANES -: LANES].
  - Within a chunk, out bit i maps to the lower-to-higher shreg index i.
- Last beat (beat == BEATS-1) with enable → done <= 1.
  - If hold_full: shreg <= hold, hold_full <= 0, beat <= 0, stay SHIFT. No idle cycle is inserted.
  - Else: state <= IDLE.
- SHIFT with enable=0: out holds its value, out_valid <= 0, done <= 0, beat and shreg frozen, busy stays 1.
- IDLE without hold_full: out holds, out_valid <= 0, done <= 0.
- Accept and hold-to-shreg transfer on the same edge is not possible, because in_ready is low while hold_full=1. With BEATS=1 the maximum throughput is one word per 2 cycles. With BEATS≥2, streaming is gapless.
- Reset mid-operation: the in-flight word and the held word are discarded. No done strobe is produced.

## Timing
- Reset values: out=0, out_valid=0, done=0, busy=0, state=IDLE, beat=0, hold_full=0. in_ready=0 during reset and 1 on the cycle after.
- Latency:
  - Word accepted at edge E.
  - Loaded into shreg at E+1; busy=1 from E+1.
  - First chunk valid after E+2 if enable is high.
  - Last chunk and done after E+1+BEATS (no stalls).
- Each stall cycle adds one cycle to done.
- busy falls on the edge that emits the last chunk when no word is held. It stays 1 across words when one is held.
- done never asserts while enable=0.

## Test plan
- SIZE=8, LANES=1, DIR=0, single word 0x1E, enable=1.
  - out sequence 0,1,1,1,1,0,0,0 on edges E+2..E+9.
  - done=1 only with the final 0; busy=0 after E+9.
- Same configuration with DIR=1, word 0x1E.
  - out sequence 0,0,0,1,1,1,1,0.
  - done on the 8th beat.
- Back-to-back: 0x1E then 0xF0, in_valid held high, DIR=0.
  - 16 consecutive out_valid cycles with no gap; done at beats 8 and 16.
  - in_ready low for exactly the cycles hold_full=1.
- SIZE=8, LANES=4, word 0x3C.
  - DIR=0 → out=0xC then 0x3.
  - DIR=1 → out=0x3 then 0xC.
  - done with the 2nd chunk.
- Stall: enable=0 for 3 cycles after beat 3 of 0xA5 (DIR=0).
  - out frozen, out_valid=0, busy=1 during the stall.
  - Remaining bits 0,1,0,1 then emitted; done 3 cycles later than unstalled.
- Reset at beat 4 with a second word held.
  - Next cycle: out=0, out_valid=0, done=0, busy=0, in_ready=1.
  - No further chunks from either word; a new word 0x01 then serializes normally.
